mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage. Consumes the ALU result as a byte address and the forwarded store value.
- Performs a word load/store on an internal data memory with a parameterised wait-state latency.
- Asserts freeze to stall all upstream stages while an access is in flight.
- Registers the MEM/WB payload for the write-back stage.

Parameters:
- DEPTH, 64: number of 32-bit words in the data memory (power of two).
- WAIT_CYCLES, 2: extra wait states per memory access (0..15).
- BASE_ADDR, 32'd1024: byte address that maps to word 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_in  in  1  EXE output holds a real instruction.
- mem_r_en  in  1  load request.
- mem_w_en  in  1  store request.
- wb_en_in  in  1  instruction writes the register file.
- dest_in  in  5  destination register.
- alu_result  in  32  ALU result / byte address from EXE.
- st_val  in  32  store data.
- freeze  out  1  stall upstream; inputs must hold stable while high.
- valid_out  out  1  MEM/WB slot valid.
- wb_en_out  out  1  registered wb_en.
- mem_r_en_out  out  1  registered load flag; selects mem_result in WB.
- dest_out  out  5  registered destination.
- alu_result_out  out  32  registered ALU result.
- mem_result  out  32  registered load data.

Behaviour:
- Reset:
  - Asynchronous, active-high.
  - All outputs, the state register and the counter clear to 0.
  - FSM goes to IDLE.
  - Memory array is not reset.
- Memory op: mem_op = valid_in & (mem_r_en | mem_w_en).
- Index: word index = ((alu_result - BASE_ADDR) >> 2) mod DEPTH. Low 2 address bits are ignored.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: mem_op → WAIT, counter loads WAIT_CYCLES. Otherwise stay in IDLE.
  - WAIT:
    - counter != 0: decrement, stay in WAIT.
    - counter == 0: perform the access on this edge, then → DONE.
      - Store: mem[index] <= st_val.
      - Load: read data captured into an internal register.
  - DONE: → IDLE unconditionally.
- freeze = mem_op & (state != DONE). It is combinational, so it rises in the same cycle the op appears. A memory op therefore freezes for exactly WAIT_CYCLES+2 cycles.
- MEM/WB output registers capture on every rising edge where freeze == 0:
  - valid_out <= valid_in.
  - All other payload fields copy from the inputs.
  - mem_result takes the captured load data on a load, 0 otherwise.
- While freeze == 1, the output registers load a bubble: valid_out = 0, wb_en_out = 0, mem_r_en_out = 0; other fields hold.
- Latency:
  - Non-memory instruction: 1 cycle.
  - Memory instruction: WAIT_CYCLES+3 cycles from first presentation to valid_out.
- Simultaneous mem_r_en & mem_w_en: treated as a store; mem_result = 0; mem_r_en_out = 0.
- valid_in = 0 with mem_r_en/mem_w_en high: no access, no freeze.
- Reset during WAIT: the access is aborted; a store is not performed if reset arrives before the WAIT→DONE edge.
- Back-to-back memory ops: after DONE the FSM returns to IDLE. The next op is accepted in the following cycle, so there is no gap beyond the single IDLE cycle.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- When defined, adds output port align_err (1 bit, reset 0). A mem_op with alu_result[1:0] != 0, or with (alu_result - BASE_ADDR) >= 4*DEPTH:
  - performs no access and does not assert freeze;
  - is registered through in 1 cycle with align_err = 1, wb_en_out = 0, mem_r_en_out = 0, valid_out = 1.
  - align_err is 0 on every other output cycle.
- When undefined: no port, low bits ignored, index wraps modulo DEPTH.

Test Plan:
- Reset mid-WAIT: assert rst while a store to 1024 is in WAIT → state IDLE, freeze 0, all outputs 0. A later load of 1024 returns the pre-reset value.
- Store then load, WAIT_CYCLES=2:
  - Store 0xDEADBEEF to 1032 → freeze high 4 cycles, then valid_out=1 with wb_en_out=0.
  - Load 1032 → mem_result=0xDEADBEEF, mem_r_en_out=1, valid_out 5 cycles after presentation.
- Non-memory pass-through: alu_result=0x12345678, wb_en_in=1, dest_in=7 → next cycle alu_result_out=0x12345678, wb_en_out=1, dest_out=7; freeze never rises.
- Wrap, DEPTH=64: store 0xA5 to 1024+256 → load from 1024 returns 0xA5.
- Both enables set: mem_r_en=mem_w_en=1, st_val=0x55, address 1040 → treated as store; mem_result=0, mem_r_en_out=0; a later load of 1040 returns 0x55.
- With MEM_ALIGN_CHECK_EN: load from 1026 → no freeze; next cycle align_err=1, valid_out=1, wb_en_out=0.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: word load/store on an internal data memory with wait states,
// freeze to stall upstream, and MEM/WB payload registers. Optional macro: MEM_ALIGN_CHECK_EN.
module mem_stage #(
    parameter int          DEPTH       = 64,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic        wb_en_in,
    input  logic [4:0]  dest_in,
    input  logic [31:0] alu_result,
    input  logic [31:0] st_val,
    output logic        freeze,
    output logic        valid_out,
    output logic        wb_en_out,
    output logic        mem_r_en_out,
    output logic [4:0]  dest_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] mem_result,
`ifdef MEM_ALIGN_CHECK_EN
    output logic        align_err,
`endif
    output logic [1:0]  dbg_state
);

    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_load_data;
    logic [31:0] r_mem [DEPTH];

    logic        r_valid_out;
    logic        r_wb_en_out;
    logic        r_mem_r_en_out;
    logic [4:0]  r_dest_out;
    logic [31:0] r_alu_result_out;
    logic [31:0] r_mem_result;
    logic        r_align_err;

    logic [31:0]      w_offset;
    logic [IDX_W-1:0] w_index;
    logic             w_mem_op;
    logic             w_bad;
    logic             w_access;
    logic             w_is_store;
    logic             w_is_load;
    logic             w_fire;
    logic             w_freeze;
    logic             w_unused_bits;

    assign w_offset   = alu_result - BASE_ADDR;
    assign w_index    = w_offset[IDX_W+1:2];
    assign w_mem_op   = valid_in & (mem_r_en | mem_w_en);
    assign w_is_store = valid_in & mem_w_en;
    assign w_is_load  = valid_in & mem_r_en & ~mem_w_en;

`ifdef MEM_ALIGN_CHECK_EN
    // A rejected op passes straight through in one cycle without touching memory.
    assign w_bad = w_mem_op & ((alu_result[1:0] != 2'b00) | (w_offset >= 32'(4 * DEPTH)));
`else
    assign w_bad = 1'b0;
`endif

    assign w_access = w_mem_op & ~w_bad;
    assign w_fire   = (r_state == S_WAIT) && (r_cnt == 4'd0);

    // freeze: while high, upstream holds its outputs stable and this stage emits bubbles;
    // the instruction is consumed on the first rising edge where freeze is low.
    assign w_freeze = w_access & (r_state != S_DONE);

    assign w_unused_bits = ^{w_offset[31:IDX_W+2], w_offset[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_load_data <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        r_state <= S_WAIT;
                        r_cnt   <= WAIT_INIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state     <= S_DONE;
                        r_load_data <= r_mem[w_index];
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The array is not reset; a store commits only on the WAIT->DONE edge.
    always_ff @(posedge clk) begin
        if (!rst && w_fire && w_access && w_is_store) begin
            r_mem[w_index] <= st_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_out      <= 1'b0;
            r_wb_en_out      <= 1'b0;
            r_mem_r_en_out   <= 1'b0;
            r_dest_out       <= 5'd0;
            r_alu_result_out <= 32'd0;
            r_mem_result     <= 32'd0;
            r_align_err      <= 1'b0;
        end else if (!w_freeze) begin
            r_valid_out      <= valid_in;
            r_wb_en_out      <= wb_en_in & ~w_bad;
            r_mem_r_en_out   <= mem_r_en & ~mem_w_en & ~w_bad;
            r_dest_out       <= dest_in;
            r_alu_result_out <= alu_result;
            r_mem_result     <= (w_is_load & ~w_bad) ? r_load_data : 32'd0;
            r_align_err      <= w_bad;
        end else begin
            r_valid_out    <= 1'b0;
            r_wb_en_out    <= 1'b0;
            r_mem_r_en_out <= 1'b0;
            r_align_err    <= 1'b0;
        end
    end

    assign freeze         = w_freeze;
    assign valid_out      = r_valid_out;
    assign wb_en_out      = r_wb_en_out;
    assign mem_r_en_out   = r_mem_r_en_out;
    assign dest_out       = r_dest_out;
    assign alu_result_out = r_alu_result_out;
    assign mem_result     = r_mem_result;
    assign dbg_state      = r_state;

`ifdef MEM_ALIGN_CHECK_EN
    assign align_err = r_align_err;
`else
    logic w_unused_align;
    assign w_unused_align = r_align_err;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table of single instructions plus hand-written
// reset-mid-access and alignment sequences.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        wb_en_in;
    logic [4:0]  dest_in;
    logic [31:0] alu_result;
    logic [31:0] st_val;
    logic        freeze;
    logic        valid_out;
    logic        wb_en_out;
    logic        mem_r_en_out;
    logic [4:0]  dest_out;
    logic [31:0] alu_result_out;
    logic [31:0] mem_result;
    logic [1:0]  dbg_state;
`ifdef MEM_ALIGN_CHECK_EN
    logic        align_err;
`endif

    int checks;
    int failures;
    logic [31:0] exp_q[$];

    mem_stage #(
        .DEPTH(64),
        .WAIT_CYCLES(2),
        .BASE_ADDR(32'd1024)
    ) dut (
        .clk(clk),
        .rst(rst),
        .valid_in(valid_in),
        .mem_r_en(mem_r_en),
        .mem_w_en(mem_w_en),
        .wb_en_in(wb_en_in),
        .dest_in(dest_in),
        .alu_result(alu_result),
        .st_val(st_val),
        .freeze(freeze),
        .valid_out(valid_out),
        .wb_en_out(wb_en_out),
        .mem_r_en_out(mem_r_en_out),
        .dest_out(dest_out),
        .alu_result_out(alu_result_out),
        .mem_result(mem_result),
`ifdef MEM_ALIGN_CHECK_EN
        .align_err(align_err),
`endif
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        string       name;
        logic        v;
        logic        r;
        logic        w;
        logic        wb;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] st;
        int          frz;
        logic        e_valid;
        logic        e_wb;
        logic        e_mre;
        logic [4:0]  e_dest;
        logic [31:0] e_alu;
        logic [31:0] e_res;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic v, input logic r, input logic w,
                           input logic wb, input logic [4:0] dest, input logic [31:0] alu,
                           input logic [31:0] st, input int frz, input logic [31:0] e_res);
        vec_t t;
        t.name    = name;
        t.v       = v;
        t.r       = r;
        t.w       = w;
        t.wb      = wb;
        t.dest    = dest;
        t.alu     = alu;
        t.st      = st;
        t.frz     = frz;
        t.e_valid = v;
        t.e_wb    = wb;
        t.e_mre   = r & ~w;
        t.e_dest  = dest;
        t.e_alu   = alu;
        t.e_res   = e_res;
        vq.push_back(t);
    endtask

    task automatic drive_idle();
        valid_in = 1'b0;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        wb_en_in = 1'b0;
    endtask

    // driver: present one instruction, hold it while frozen, then drop to idle; returns
    // at the negedge of the cycle in which the instruction shows on the MEM/WB outputs
    task automatic run_instr(input logic v, input logic r, input logic w, input logic wb,
                             input logic [4:0] d, input logic [31:0] a, input logic [31:0] s,
                             output int frz);
        bit done;
        @(posedge clk);
        #1;
        valid_in   = v;
        mem_r_en   = r;
        mem_w_en   = w;
        wb_en_in   = wb;
        dest_in    = d;
        alu_result = a;
        st_val     = s;
        frz        = 0;
        done       = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (freeze) begin
                frz++;
                if (frz > 1) chk("bubble_valid", {31'd0, valid_out}, 32'd0);
                @(posedge clk);
                #1;
            end else begin
                done = 1'b1;
            end
        end
        if (!done) chk("freeze_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        drive_idle();
        @(negedge clk);
    endtask

    initial begin
        int frz;
        vec_t t;
        checks   = 0;
        failures = 0;

        add_vec("pass_thru",   1'b1, 1'b0, 1'b0, 1'b1, 5'd7,  32'h12345678, 32'h0,        0, 32'h0);
        add_vec("store_1032",  1'b1, 1'b0, 1'b1, 1'b0, 5'd0,  32'd1032,     32'hDEADBEEF, 4, 32'h0);
        add_vec("load_1032",   1'b1, 1'b1, 1'b0, 1'b1, 5'd3,  32'd1032,     32'h0,        4, 32'hDEADBEEF);
`ifndef MEM_ALIGN_CHECK_EN
        add_vec("store_wrap",  1'b1, 1'b0, 1'b1, 1'b0, 5'd0,  32'd1280,     32'h000000A5, 4, 32'h0);
        add_vec("load_wrap",   1'b1, 1'b1, 1'b0, 1'b1, 5'd9,  32'd1024,     32'h0,        4, 32'h000000A5);
`endif
        add_vec("both_en",     1'b1, 1'b1, 1'b1, 1'b0, 5'd2,  32'd1040,     32'h00000055, 4, 32'h0);
        add_vec("load_1040",   1'b1, 1'b1, 1'b0, 1'b1, 5'd12, 32'd1040,     32'h0,        4, 32'h00000055);
        add_vec("invalid_st",  1'b0, 1'b0, 1'b1, 1'b0, 5'd1,  32'd1032,     32'h11111111, 0, 32'h0);
        add_vec("reload_1032", 1'b1, 1'b1, 1'b0, 1'b1, 5'd4,  32'd1032,     32'h0,        4, 32'hDEADBEEF);
`ifndef MEM_ALIGN_CHECK_EN
        add_vec("low_bits",    1'b1, 1'b1, 1'b0, 1'b1, 5'd5,  32'd1035,     32'h0,        4, 32'hDEADBEEF);
`endif
        add_vec("pass_thru2",  1'b1, 1'b0, 1'b0, 1'b0, 5'd31, 32'hFFFFFFFF, 32'h0,        0, 32'h0);

        rst = 1'b1;
        drive_idle();
        dest_in    = 5'd0;
        alu_result = 32'd0;
        st_val     = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state",     {30'd0, dbg_state},    32'd0);
        chk("rst_freeze",    {31'd0, freeze},       32'd0);
        chk("rst_valid_out", {31'd0, valid_out},    32'd0);
        chk("rst_alu_out",   alu_result_out,        32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            t = vq[i];
            exp_q.push_back(t.e_res);
            run_instr(t.v, t.r, t.w, t.wb, t.dest, t.alu, t.st, frz);
            chk({t.name, "_freeze_cycles"}, 32'(frz),               32'(t.frz));
            chk({t.name, "_valid_out"},     {31'd0, valid_out},     {31'd0, t.e_valid});
            chk({t.name, "_wb_en_out"},     {31'd0, wb_en_out},     {31'd0, t.e_wb});
            chk({t.name, "_mem_r_en_out"},  {31'd0, mem_r_en_out},  {31'd0, t.e_mre});
            chk({t.name, "_dest_out"},      {27'd0, dest_out},      {27'd0, t.e_dest});
            chk({t.name, "_alu_out"},       alu_result_out,         t.e_alu);
            chk({t.name, "_mem_result"},    mem_result,             exp_q.pop_front());
        end

        // reset while a store sits in WAIT: store must be dropped
        run_instr(1'b1, 1'b0, 1'b1, 1'b0, 5'd6, 32'd1024, 32'h0BADF00D, frz);
        chk("pre_store_freeze", 32'(frz), 32'd4);
        @(posedge clk);
        #1;
        valid_in   = 1'b1;
        mem_w_en   = 1'b1;
        dest_in    = 5'd6;
        alu_result = 32'd1024;
        st_val     = 32'hCAFEF00D;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("mid_wait_state", {30'd0, dbg_state}, 32'd1);
        rst = 1'b1;
        drive_idle();
        #1;
        chk("rst_wait_state",   {30'd0, dbg_state},    32'd0);
        chk("rst_wait_freeze",  {31'd0, freeze},       32'd0);
        chk("rst_wait_valid",   {31'd0, valid_out},    32'd0);
        chk("rst_wait_dest",    {27'd0, dest_out},     32'd0);
        chk("rst_wait_alu",     alu_result_out,        32'd0);
        chk("rst_wait_result",  mem_result,            32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_instr(1'b1, 1'b1, 1'b0, 1'b1, 5'd8, 32'd1024, 32'h0, frz);
        chk("post_rst_freeze", 32'(frz),  32'd4);
        chk("post_rst_load",   mem_result, 32'h0BADF00D);
        chk("post_rst_mre",    {31'd0, mem_r_en_out}, 32'd1);

`ifdef MEM_ALIGN_CHECK_EN
        run_instr(1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 32'd1026, 32'h0, frz);
        chk("align_freeze",    32'(frz),              32'd0);
        chk("align_err",       {31'd0, align_err},    32'd1);
        chk("align_valid",     {31'd0, valid_out},    32'd1);
        chk("align_wb",        {31'd0, wb_en_out},    32'd0);
        chk("align_mre",       {31'd0, mem_r_en_out}, 32'd0);
        run_instr(1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 32'd1280, 32'h0, frz);
        chk("range_freeze",    32'(frz),              32'd0);
        chk("range_err",       {31'd0, align_err},    32'd1);
        run_instr(1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 32'd1032, 32'h0, frz);
        chk("aligned_err",     {31'd0, align_err},    32'd0);
        chk("aligned_load",    mem_result,            32'hDEADBEEF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
